multicore_nios_cpu_debug_mem_ctrl: RTL and testbench

Sysclk-domain sequencer between the Nios debug-slave command strobes (take_action_ocimem_*, jdo) and a shared debug/monitor RAM that the CPU also uses.
- Decodes JTAG memory commands, requests the RAM port, waits for grant and fixed read latency.
- Returns MonDReg with the monitor_ready/monitor_error handshake; address auto-increments.
- Sits beside the debug-slave wrapper inside each core of the multicore system.

---
 rtl/multicore_nios_cpu_debug_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_multicore_nios_cpu_debug_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_nios_cpu_debug_mem_ctrl.sv
// Debug-slave memory sequencer: JTAG ocimem commands to a shared debug RAM.
// Optional REQ timeout when MULTICORE_DEBUG_MEM_TIMEOUT_EN is defined.
module multicore_nios_cpu_debug_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 2,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
    $error("RD_LAT must be 1..7");
  end
  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("TMO_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LAT,
    DONE
  } state_e;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              inc_q, inc_d;
  logic [2:0]        lat_q, lat_d;
  logic [31:0]       mon_q, mon_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

`ifdef MULTICORE_DEBUG_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic any_stb;
  logic cmd_wr, cmd_ld, cmd_rd, cmd_nrd;

  // Fixed priority: ocimem_b over ocimem_a over no_action.
  assign any_stb = take_action_ocimem_a | take_no_action_ocimem_a
                 | take_action_ocimem_b;
  assign cmd_wr  = take_action_ocimem_b;
  assign cmd_ld  = !cmd_wr && take_action_ocimem_a && jdo[35];
  assign cmd_rd  = !cmd_wr && take_action_ocimem_a && !jdo[35];
  assign cmd_nrd = !cmd_wr && !take_action_ocimem_a
                 && take_no_action_ocimem_a;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    inc_d   = inc_q;
    lat_d   = lat_q;
    mon_d   = mon_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
`ifdef MULTICORE_DEBUG_MEM_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef MULTICORE_DEBUG_MEM_TIMEOUT_EN
        tmo_d = '0;
`endif
        unique case (1'b1)
          cmd_wr: begin
            wdata_d = jdo[34:3];
            we_d    = 1'b1;
            inc_d   = 1'b1;
            rdy_d   = 1'b0;
            state_d = REQ;
          end
          cmd_ld: begin
            addr_d = jdo[ADDR_W+16:17];
            err_d  = 1'b0;
          end
          cmd_rd: begin
            we_d    = 1'b0;
            inc_d   = 1'b0;
            rdy_d   = 1'b0;
            state_d = REQ;
          end
          cmd_nrd: begin
            we_d    = 1'b0;
            inc_d   = 1'b1;
            rdy_d   = 1'b0;
            state_d = REQ;
          end
          default: ;
        endcase
      end
      REQ: begin
        if (any_stb) err_d = 1'b1;
        if (mem_gnt) begin
          if (we_q) begin
            mon_d   = wdata_q;
            state_d = DONE;
          end else begin
            lat_d   = LAT_INIT;
            state_d = LAT;
          end
        end
`ifdef MULTICORE_DEBUG_MEM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          mon_d   = 32'hDEAD_BEEF;
          err_d   = 1'b1;
          inc_d   = 1'b0;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      LAT: begin
        if (any_stb) err_d = 1'b1;
        if (lat_q == 3'd0) begin
          mon_d   = mem_rdata;
          state_d = DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      DONE: begin
        if (any_stb) err_d = 1'b1;
        if (inc_q) addr_d = addr_q + 1'b1;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      inc_q   <= 1'b0;
      lat_q   <= '0;
      mon_q   <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
`ifdef MULTICORE_DEBUG_MEM_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      inc_q   <= inc_d;
      lat_q   <= lat_d;
      mon_q   <= mon_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
`ifdef MULTICORE_DEBUG_MEM_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign mem_req       = (state_q == REQ);
  assign mem_we        = mem_req & we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_multicore_nios_cpu_debug_mem_ctrl.sv
// Directed bench for the debug memory sequencer with a small RAM model.
module tb_multicore_nios_cpu_debug_mem_ctrl;

  localparam int ADDR_W  = 8;
  localparam int RD_LAT  = 2;
  localparam int TMO_CYC = 255;

  logic        clk;
  logic        reset_n;
  logic        stb_a, stb_na, stb_b;
  logic [37:0] jdo;
  logic        mem_req, mem_we, mem_gnt;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, MonDReg;
  logic        monitor_ready, monitor_error, busy;
  logic        gnt_en;

  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;

  logic [31:0]       ram   [256];
  bit                wr_v  [256];
  bit [RD_LAT-1:0]   pipe_v;
  logic [31:0]       pipe_d [RD_LAT];

  multicore_nios_cpu_debug_mem_ctrl #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .TMO_CYC(TMO_CYC)
  ) u_dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .take_action_ocimem_a   (stb_a),
    .take_no_action_ocimem_a(stb_na),
    .take_action_ocimem_b   (stb_b),
    .jdo                    (jdo),
    .mem_req                (mem_req),
    .mem_we                 (mem_we),
    .mem_addr               (mem_addr),
    .mem_wdata              (mem_wdata),
    .mem_gnt                (mem_gnt),
    .mem_rdata              (mem_rdata),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .busy                   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_gnt   = gnt_en;
  assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1]
                                      : 32'hBAD0_BAD0;

  // Unwritten words read as 12345678 with the address xored into the top byte.
  function automatic logic [31:0] ram_rd(input logic [7:0] a);
    return wr_v[a] ? ram[a] : (32'h1234_5678 ^ {a, 24'h0});
  endfunction

  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    pipe_v[0] <= 1'b0;
    if (mem_req && mem_gnt) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_we) begin
        ram[mem_addr]  <= mem_wdata;
        wr_v[mem_addr] <= 1'b1;
      end else begin
        pipe_v[0] <= 1'b1;
        pipe_d[0] <= ram_rd(mem_addr);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jload(input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = 1'b1;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jwr(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Pulse strobes for one cycle; lat = cycles from strobe to monitor_ready.
  task automatic cmd(input logic b, input logic a, input logic na,
                     input logic [37:0] j, output int lat);
    jdo = j;
    stb_b = b;
    stb_a = a;
    stb_na = na;
    tick();
    stb_b = 1'b0;
    stb_a = 1'b0;
    stb_na = 1'b0;
    lat = 1;
    while (!monitor_ready && lat < 600) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int a0;
    int stable;
    logic [37:0] j;
    reset_n = 1'b0;
    stb_a = 1'b0;
    stb_na = 1'b0;
    stb_b = 1'b0;
    jdo = '0;
    gnt_en = 1'b1;
    tick();
    tick();
    check("rst_ctl", {mem_req, mem_we, busy, monitor_ready, monitor_error},
          5'b00010);
    check("rst_mon", MonDReg, 32'h0);
    check("rst_addr", mem_addr, 8'h00);
    reset_n = 1'b1;
    tick();

    cmd(1'b0, 1'b1, 1'b0, jload(8'h10), lat);
    check("ld_lat", lat, 1);
    check("ld_ctl", {mem_req, busy, monitor_ready}, 3'b001);
    check("ld_addr", mem_addr, 8'h10);

    a0 = acc_cnt;
    jdo = jwr(32'hCAFE_F00D);
    stb_b = 1'b1;
    tick();
    stb_b = 1'b0;
    check("wr_req", {mem_req, mem_we, busy, monitor_ready}, 4'b1110);
    check("wr_addr", mem_addr, 8'h10);
    check("wr_data", mem_wdata, 32'hCAFE_F00D);
    tick();
    check("wr_done", {mem_req, monitor_ready}, 2'b00);
    check("wr_echo", MonDReg, 32'hCAFE_F00D);
    tick();
    check("wr_ready", {monitor_ready, busy}, 2'b10);
    check("wr_inc", mem_addr, 8'h11);
    check("wr_ram", ram[8'h10], 32'hCAFE_F00D);
    check("wr_acc", acc_cnt - a0, 1);

    cmd(1'b0, 1'b0, 1'b1, '0, lat);
    check("nrd_lat", lat, 5);
    check("nrd_data", MonDReg, 32'h0334_5678);
    check("nrd_inc", mem_addr, 8'h12);

    cmd(1'b0, 1'b1, 1'b0, '0, lat);
    check("rd_lat", lat, 5);
    check("rd_data", MonDReg, 32'h0034_5678);
    check("rd_noinc", mem_addr, 8'h12);

    cmd(1'b0, 1'b1, 1'b0, jload(8'hFF), lat);
    cmd(1'b0, 1'b0, 1'b1, '0, lat);
    check("wrap_data", MonDReg, 32'hED34_5678);
    check("wrap_addr", mem_addr, 8'h00);

    a0 = acc_cnt;
    j = jwr(32'h1111_2222);
    j[35] = 1'b1;
    cmd(1'b1, 1'b1, 1'b1, j, lat);
    check("pri_lat", lat, 3);
    check("pri_ram", ram[8'h00], 32'h1111_2222);
    check("pri_addr", mem_addr, 8'h01);
    check("pri_acc", acc_cnt - a0, 1);
    check("pri_err", monitor_error, 1'b0);
    cmd(1'b0, 1'b1, 1'b1, '0, lat);
    check("pri2_data", MonDReg, 32'h1334_5678);
    check("pri2_addr", mem_addr, 8'h01);

    cmd(1'b0, 1'b1, 1'b0, jload(8'h20), lat);
    gnt_en = 1'b0;
    a0 = acc_cnt;
    jdo = jwr(32'h5555_AAAA);
    stb_b = 1'b1;
    tick();
    stb_b = 1'b0;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && mem_we && mem_addr == 8'h20
          && mem_wdata == 32'h5555_AAAA && !monitor_ready)
        stable++;
      if (i == 4) begin
        jdo = jwr(32'h7777_7777);
        stb_b = 1'b1;
      end
      tick();
      stb_b = 1'b0;
    end
    check("hold_req", stable, 10);
    check("hold_err", monitor_error, 1'b1);
    gnt_en = 1'b1;
    lat = 0;
    while (!monitor_ready && lat < 20) begin
      tick();
      lat++;
    end
    check("hold_lat", lat, 2);
    check("hold_acc", acc_cnt - a0, 1);
    check("hold_ram", ram[8'h20], 32'h5555_AAAA);
    check("hold_mon", MonDReg, 32'h5555_AAAA);
    check("hold_err2", monitor_error, 1'b1);
    check("hold_addr", mem_addr, 8'h21);
    cmd(1'b0, 1'b1, 1'b0, jload(8'h30), lat);
    check("clr_err", monitor_error, 1'b0);

    jdo = '0;
    stb_na = 1'b1;
    tick();
    tick();
    stb_na = 1'b0;
    check("lat_busy", {busy, mem_req, monitor_error}, 3'b101);
    reset_n = 1'b0;
    #2;
    check("rstlat_ctl",
          {mem_req, mem_we, busy, monitor_ready, monitor_error}, 5'b00010);
    check("rstlat_mon", MonDReg, 32'h0);
    check("rstlat_addr", mem_addr, 8'h00);
    check("rstlat_wd", mem_wdata, 32'h0);
    #2;
    reset_n = 1'b1;
    tick();
    cmd(1'b0, 1'b0, 1'b1, '0, lat);
    check("post_lat", lat, 5);
    check("post_data", MonDReg, 32'h1111_2222);
    check("post_addr", mem_addr, 8'h01);

`ifdef MULTICORE_DEBUG_MEM_TIMEOUT_EN
    cmd(1'b0, 1'b1, 1'b0, jload(8'h40), lat);
    gnt_en = 1'b0;
    a0 = acc_cnt;
    cmd(1'b1, 1'b0, 1'b0, jwr(32'h0000_9999), lat);
    check("tmo_lat", lat, TMO_CYC + 2);
    check("tmo_mon", MonDReg, 32'hDEAD_BEEF);
    check("tmo_err", monitor_error, 1'b1);
    check("tmo_addr", mem_addr, 8'h40);
    check("tmo_acc", acc_cnt - a0, 0);
    gnt_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
